// File: rtl/sp_master.sv
`default_nettype none
// ============================================================================
// sp_master : board-side initiator of the two-wire serial packet link
// Revision  : 1.0
// ============================================================================
module sp_master #(
  parameter int CLK_DIV = 4,
  parameter int PAUSE   = 300,
  parameter int W       = 8
) (
  input  logic         MAIN_CLK,
  input  logic         RESET_N,
  input  logic         start,
  input  logic [W-1:0] dev_id,
  input  logic [W-1:0] cmd_in,
  input  logic [W-1:0] data_in_1,
  input  logic [W-1:0] data_in_2,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] cmd_out,
  output logic [W-1:0] data_out_1,
  output logic [W-1:0] data_out_2,
  output logic         link_ok,
  output logic         S_CLK_BRD,
  inout  wire          S_DATA_BRD
);

  localparam int TX_BITS = 4 * W;
  localparam int RX_BITS = 3 * W;
  localparam int PH_W    = $clog2(2 * CLK_DIV);
  localparam int BIT_W   = $clog2(TX_BITS + 1);
  localparam int PC_W    = $clog2(PAUSE + 1);

  localparam logic [PH_W-1:0]  PH_RISE    = PH_W'(CLK_DIV - 1);
  localparam logic [PH_W-1:0]  PH_LAST    = PH_W'(2 * CLK_DIV - 1);
  localparam logic [BIT_W-1:0] TX_LAST    = BIT_W'(TX_BITS - 1);
  localparam logic [BIT_W-1:0] RX_LAST    = BIT_W'(RX_BITS - 1);
  localparam logic [PC_W-1:0]  PAUSE_LAST = PC_W'(PAUSE - 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_TX   = 3'd1,
    ST_WAIT = 3'd2,
    ST_RX   = 3'd3,
    ST_FIN  = 3'd4
  } state_t;

  state_t             state;
  logic [TX_BITS-1:0] tx_sr;
  logic [RX_BITS-1:0] rx_sr;
  logic [W-1:0]       cmd_lat;
  logic [PH_W-1:0]    phase;
  logic [BIT_W-1:0]   bit_cnt;
  logic [PC_W-1:0]    pause_cnt;
  logic               data_oe;

  assign S_DATA_BRD = data_oe ? tx_sr[TX_BITS-1] : 1'bz;

  // phase counts MAIN_CLK cycles inside a bit cell: low half first, then high half
  always_ff @(posedge MAIN_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= ST_IDLE;
      tx_sr      <= '0;
      rx_sr      <= '0;
      cmd_lat    <= '0;
      phase      <= '0;
      bit_cnt    <= '0;
      pause_cnt  <= '0;
      data_oe    <= 1'b0;
      S_CLK_BRD  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      cmd_out    <= '0;
      data_out_1 <= '0;
      data_out_2 <= '0;
      link_ok    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          // a start coinciding with the done pulse is ignored
          if (start && !done) begin
            tx_sr     <= {dev_id, cmd_in, data_in_1, data_in_2};
            cmd_lat   <= cmd_in;
            phase     <= '0;
            bit_cnt   <= '0;
            busy      <= 1'b1;
            data_oe   <= 1'b1;
            S_CLK_BRD <= 1'b0;
            state     <= ST_TX;
          end
        end

        ST_TX: begin
          if (phase == PH_LAST) begin
            phase <= '0;
            tx_sr <= {tx_sr[TX_BITS-2:0], 1'b0};
            if (bit_cnt == TX_LAST) begin
              data_oe   <= 1'b0;
              S_CLK_BRD <= 1'b1;
              pause_cnt <= '0;
              bit_cnt   <= '0;
              state     <= ST_WAIT;
            end else begin
              bit_cnt   <= bit_cnt + 1'b1;
              S_CLK_BRD <= 1'b0;
            end
          end else begin
            phase <= phase + 1'b1;
            if (phase == PH_RISE) begin
              S_CLK_BRD <= 1'b1;
            end
          end
        end

        ST_WAIT: begin
          if (pause_cnt == PAUSE_LAST) begin
            phase     <= '0;
            bit_cnt   <= '0;
            S_CLK_BRD <= 1'b0;
            state     <= ST_RX;
          end else begin
            pause_cnt <= pause_cnt + 1'b1;
          end
        end

        ST_RX: begin
          if (phase == PH_LAST) begin
            phase <= '0;
            if (bit_cnt == RX_LAST) begin
              state <= ST_FIN;
            end else begin
              bit_cnt   <= bit_cnt + 1'b1;
              S_CLK_BRD <= 1'b0;
            end
          end else begin
            phase <= phase + 1'b1;
            // sample on the cycle S_CLK rises; the slave drove during the low half
            if (phase == PH_RISE) begin
              S_CLK_BRD <= 1'b1;
              rx_sr     <= {rx_sr[RX_BITS-2:0], S_DATA_BRD};
            end
          end
        end

        ST_FIN: begin
          cmd_out    <= rx_sr[3*W-1:2*W];
          data_out_1 <= rx_sr[2*W-1:W];
          data_out_2 <= rx_sr[W-1:0];
          link_ok    <= (rx_sr[3*W-1:2*W] == cmd_lat);
          done       <= 1'b1;
          busy       <= 1'b0;
          state      <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sp_master.sv
`default_nettype none
// ============================================================================
// tb_sp_master : two sp_master instances (default and fast timing) against
//                a behavioural slave and frame-level reference model
// Revision     : 1.0
// ============================================================================
module tb_sp_master;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] start = 2'b00;
  logic [7:0] dev_id = '0, cmd_in = '0, data_in_1 = '0, data_in_2 = '0;
  logic [1:0] present = 2'b00;
  logic [23:0] rep [2];

  wire [1:0]  busy, done, link_ok, s_clk;
  wire [7:0]  cmd_out [2];
  wire [7:0]  dout1 [2];
  wire [7:0]  dout2 [2];
  wire        line_w [2];
  wire [31:0] ndone_w [2];
  wire [31:0] tdone_w [2];
  wire [31:0] reqcap_w [2];

  int cyc = 0;
  int vectors = 0;
  int errors = 0;
  int lat_exp [2] = '{1 + 112 * 4 + 300, 1 + 112 * 2 + 260};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar i = 0; i < 2; i++) begin : g_dut
    localparam int CD = (i == 0) ? 4 : 2;
    localparam int PS = (i == 0) ? 300 : 260;

    wire         sd;
    logic        soe = 1'b0, sbit = 1'b0, prev = 1'b1;
    logic        rsp = 1'b0;
    int          cnt = 0, ndone = 0, t_done = 0;
    logic [31:0] shreq = '0, req_cap = '0;

    pullup pu (sd);
    assign sd = soe ? sbit : 1'bz;
    assign line_w[i]   = sd;
    assign ndone_w[i]  = ndone;
    assign tdone_w[i]  = t_done;
    assign reqcap_w[i] = req_cap;

    sp_master #(.CLK_DIV(CD), .PAUSE(PS), .W(8)) u_dut (
      .MAIN_CLK  (clk),
      .RESET_N   (rst_n),
      .start     (start[i]),
      .dev_id    (dev_id),
      .cmd_in    (cmd_in),
      .data_in_1 (data_in_1),
      .data_in_2 (data_in_2),
      .busy      (busy[i]),
      .done      (done[i]),
      .cmd_out   (cmd_out[i]),
      .data_out_1(dout1[i]),
      .data_out_2(dout2[i]),
      .link_ok   (link_ok[i]),
      .S_CLK_BRD (s_clk[i]),
      .S_DATA_BRD(sd)
    );

    // Slave: capture 32 request bits on S_CLK rises, then drive 24 reply bits
    // from each S_CLK fall (only when present), release after the last rise.
    always @(negedge clk) begin
      if (!rst_n) begin
        prev <= 1'b1;
        rsp  <= 1'b0;
        cnt  <= 0;
        soe  <= 1'b0;
      end else begin
        prev <= s_clk[i];
        if (done[i]) begin
          ndone  <= ndone + 1;
          t_done <= cyc;
        end
        if (!rsp) begin
          if (s_clk[i] && !prev) begin
            shreq <= {shreq[30:0], sd};
            if (cnt == 31) begin
              req_cap <= {shreq[30:0], sd};
              rsp     <= 1'b1;
              cnt     <= 0;
            end else begin
              cnt <= cnt + 1;
            end
          end
        end else begin
          if (!s_clk[i] && prev && cnt < 24) begin
            soe  <= present[i];
            sbit <= rep[i][23 - cnt];
            cnt  <= cnt + 1;
          end else if (s_clk[i] && !prev && cnt == 24) begin
            soe <= 1'b0;
            rsp <= 1'b0;
            cnt <= 0;
          end
        end
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_frames(input int base0, input int base1, input logic [1:0] which);
    int n = 0;
    while (((which[0] && ndone_w[0] == 32'(base0)) || (which[1] && ndone_w[1] == 32'(base1)))
           && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_eq("done_within_budget", 32'(n < 2000), 32'd1);
  endtask

  task automatic check_idle_reset(input string tag);
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("%s_sclk_u%0d", tag, i), 32'(s_clk[i]), 32'd1);
      check_eq($sformatf("%s_line_u%0d", tag, i), 32'(line_w[i]), 32'd1);
      check_eq($sformatf("%s_busy_u%0d", tag, i), 32'(busy[i]), 32'd0);
      check_eq($sformatf("%s_done_u%0d", tag, i), 32'(done[i]), 32'd0);
      check_eq($sformatf("%s_reply_u%0d", tag, i), {7'd0, link_ok[i], cmd_out[i], dout1[i], dout2[i]}, 32'd0);
    end
  endtask

  // Runs one frame on both instances and compares against the frame-level model.
  task automatic run_frame(input logic [7:0] di, input logic [7:0] ci, input logic [7:0] a1,
                           input logic [7:0] a2, input logic [1:0] pres,
                           input logic [23:0] r0, input logic [23:0] r1);
    int b0, b1, t0;
    logic [23:0] exp;
    dev_id = di; cmd_in = ci; data_in_1 = a1; data_in_2 = a2;
    present = pres; rep[0] = r0; rep[1] = r1;
    b0 = ndone_w[0]; b1 = ndone_w[1];
    start = 2'b11;
    @(negedge clk);
    t0 = cyc;
    start = 2'b00;
    dev_id = 8'($urandom); cmd_in = 8'($urandom);
    data_in_1 = 8'($urandom); data_in_2 = 8'($urandom);
    wait_frames(b0, b1, 2'b11);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      exp = pres[i] ? ((i == 0) ? r0 : r1) : 24'hFFFFFF;
      check_eq($sformatf("latency_u%0d", i), tdone_w[i] - 32'(t0), 32'(lat_exp[i]));
      check_eq($sformatf("request_u%0d", i), reqcap_w[i], {di, ci, a1, a2});
      check_eq($sformatf("reply_u%0d", i), {8'd0, cmd_out[i], dout1[i], dout2[i]}, {8'd0, exp});
      check_eq($sformatf("link_ok_u%0d", i), 32'(link_ok[i]), 32'(exp[23:16] == ci));
      check_eq($sformatf("one_done_u%0d", i), ndone_w[i] - 32'((i == 0) ? b0 : b1), 32'd1);
      check_eq($sformatf("busy_after_u%0d", i), 32'(busy[i]), 32'd0);
    end
  endtask

  initial begin
    int b0, b1, t0, n;
    logic [7:0]  ci;
    logic [23:0] r0, r1;
    rep[0] = '0; rep[1] = '0;

    repeat (3) @(negedge clk);
    check_idle_reset("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_frame(8'hA5, 8'h02, 8'h10, 8'h00, 2'b11, 24'h023CC3, 24'h023CC3);
    run_frame(8'h12, 8'h05, 8'h34, 8'h56, 2'b00, 24'h0, 24'h0);
    run_frame(8'h77, 8'h06, 8'h00, 8'hFF, 2'b11, 24'h071122, 24'h071122);

    for (int k = 0; k < 6; k++) begin
      ci = 8'($urandom_range(0, 254));
      r0 = {($urandom_range(0, 1) == 1) ? ci : 8'($urandom), 16'($urandom)};
      r1 = {($urandom_range(0, 1) == 1) ? ci : 8'($urandom), 16'($urandom)};
      run_frame(8'($urandom), ci, 8'($urandom), 8'($urandom), 2'($urandom), r0, r1);
    end

    // start held through a whole frame with inputs changed mid-frame (unit 0)
    present = 2'b01; rep[0] = 24'h4A0102;
    dev_id = 8'h3C; cmd_in = 8'h4A; data_in_1 = 8'h01; data_in_2 = 8'h02;
    b0 = ndone_w[0];
    start = 2'b01;
    @(negedge clk);
    t0 = cyc;
    repeat (100) @(negedge clk);
    dev_id = 8'hC3; cmd_in = 8'h5B; data_in_1 = 8'h0E; data_in_2 = 8'h0F;
    n = 0;
    while (done[0] !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_eq("held_done_seen", 32'(n < 2000), 32'd1);
    check_eq("held_latency1", 32'(cyc - t0), 32'(lat_exp[0]));
    check_eq("held_busy_at_done", 32'(busy[0]), 32'd0);
    check_eq("held_reply1", {8'd0, cmd_out[0], dout1[0], dout2[0]}, 32'h004A0102);
    check_eq("held_link1", 32'(link_ok[0]), 32'd1);
    check_eq("held_request1", reqcap_w[0], 32'h3C4A0102);
    rep[0] = 24'h5B7788;
    @(negedge clk);
    check_eq("held_gap_busy", {30'd0, busy[0], done[0]}, 32'd0);
    @(negedge clk);
    check_eq("held_restart_busy", 32'(busy[0]), 32'd1);
    t0 = cyc;
    start = 2'b00;
    wait_frames(b0 + 1, 0, 2'b01);
    repeat (2) @(negedge clk);
    check_eq("held_latency2", tdone_w[0] - 32'(t0), 32'(lat_exp[0]));
    check_eq("held_reply2", {8'd0, cmd_out[0], dout1[0], dout2[0]}, 32'h005B7788);
    check_eq("held_link2", 32'(link_ok[0]), 32'd1);
    check_eq("held_request2", reqcap_w[0], 32'hC35B0E0F);
    check_eq("held_done_count", ndone_w[0] - 32'(b0), 32'd2);

    // reset asserted while both units sit in the pause window
    present = 2'b11; rep[0] = 24'h219999; rep[1] = 24'h219999;
    dev_id = 8'h01; cmd_in = 8'h21; data_in_1 = 8'h02; data_in_2 = 8'h03;
    b0 = ndone_w[0]; b1 = ndone_w[1];
    start = 2'b11;
    @(negedge clk);
    start = 2'b00;
    repeat (300) @(negedge clk);
    check_eq("pre_reset_busy", 32'(busy), 32'd3);
    rst_n = 1'b0;
    #1;
    check_idle_reset("abort");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (800) @(negedge clk);
    check_eq("abort_no_done_u0", ndone_w[0], 32'(b0));
    check_eq("abort_no_done_u1", ndone_w[1], 32'(b1));
    run_frame(8'hB2, 8'h33, 8'h44, 8'h55, 2'b11, 24'h33ABCD, 24'h33DCBA);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got expired expected finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule
`default_nettype wire
